// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
//   keeps at most one fetch outstanding to a variable-latency instruction
//   memory, buffers a returned instruction while IF/ID is stalled, and
//   discards wrong-path responses after a branch/jump redirect.
//
// Ports
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   imem_req / imem_addr  one-cycle fetch strobe and its address (always pc)
//   imem_rdata/imem_valid instruction returned by memory and its strobe
//   stall                 IF/ID must not be written this cycle
//   redirect/redirect_pc  taken branch/jump and its target (low 2 bits dropped)
//   insout / pcnextout    instruction and its PC+4 toward IF/ID
//   ifid_wr / ifid_flush  IF/ID write enable and flush
//
// Handshake: imem_req is a single-cycle strobe issued only from S_REQ; the
// memory answers exactly once with imem_valid one or more cycles later. There
// is no ready/backpressure on the memory side, which is why a response that
// becomes wrong-path must still be waited for (S_DROP) before the next
// request may be issued. ifid_wr is a one-cycle write strobe qualified by
// !stall and !redirect.
//
// The FSM state is kept in the signal 'state' for hierarchical observation.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int                INSWIDTH = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] RESET_PC = {AWIDTH{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [AWIDTH-1:0]   imem_addr,
  input  logic [INSWIDTH-1:0] imem_rdata,
  input  logic                imem_valid,
  input  logic                stall,
  input  logic                redirect,
  input  logic [AWIDTH-1:0]   redirect_pc,
  output logic [INSWIDTH-1:0] insout,
  output logic [AWIDTH-1:0]   pcnextout,
  output logic                ifid_wr,
  output logic                ifid_flush
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  localparam logic [AWIDTH-1:0] PC_STEP = AWIDTH'(4);

  state_t                state, state_nxt;
  logic [AWIDTH-1:0]     pc, pc_nxt;
  logic [INSWIDTH-1:0]   hold_ins, hold_nxt;
  logic                  req_raw, wr_raw;
  logic [AWIDTH-1:0]     pc_inc;
  logic [AWIDTH-1:0]     redir_aligned;

  // Natural wrap at 2^AWIDTH is intended.
  assign pc_inc        = pc + PC_STEP;
  assign redir_aligned = {redirect_pc[AWIDTH-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      hold_ins <= '0;
      state    <= S_REQ;
    end else begin
      pc       <= pc_nxt;
      hold_ins <= hold_nxt;
      state    <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    hold_nxt  = hold_ins;
    req_raw   = 1'b0;
    wr_raw    = 1'b0;
    insout    = imem_rdata;

    case (state)
      S_REQ: begin
        // Any imem_valid seen here is unsolicited and ignored.
        req_raw = 1'b1;
        if (redirect) begin
          // The request issued this cycle is already wrong-path.
          pc_nxt    = redir_aligned;
          state_nxt = S_DROP;
        end else begin
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          pc_nxt    = redir_aligned;
          // If the response lands now it is simply dropped; otherwise it is
          // still in flight and must be absorbed in S_DROP.
          state_nxt = imem_valid ? S_REQ : S_DROP;
        end else if (imem_valid) begin
          if (stall) begin
            hold_nxt  = imem_rdata;
            state_nxt = S_HOLD;
          end else begin
            wr_raw    = 1'b1;
            pc_nxt    = pc_inc;
            state_nxt = S_REQ;
          end
        end
      end

      S_HOLD: begin
        insout = hold_ins;
        if (redirect) begin
          pc_nxt    = redir_aligned;
          state_nxt = S_REQ;
        end else if (!stall) begin
          wr_raw    = 1'b1;
          pc_nxt    = pc_inc;
          state_nxt = S_REQ;
        end
      end

      S_DROP: begin
        if (redirect) begin
          pc_nxt = redir_aligned;
        end
        if (imem_valid) begin
          state_nxt = S_REQ;
        end
      end

      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  assign imem_req   = req_raw & rst_n;
  assign ifid_wr    = wr_raw & rst_n;
  assign ifid_flush = redirect & rst_n;
  assign imem_addr  = pc;
  assign pcnextout  = pc_inc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//   Drives the fetch unit with a small variable-latency memory model, directed
//   scenarios and a long randomized run. The reference keeps the fetch
//   status as plain flags (request outstanding, outstanding one is wrong-path,
//   instruction held) and derives the expected outputs from them each cycle.
//   A second instance with RESET_PC = 32'hFFFF_FFFC covers the PC wrap.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] insout;
  logic [31:0] pcnextout;
  logic        ifid_wr;
  logic        ifid_flush;

  if_fetch_unit #(.INSWIDTH(32), .AWIDTH(32), .RESET_PC(RST_PC)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .insout(insout), .pcnextout(pcnextout),
    .ifid_wr(ifid_wr), .ifid_flush(ifid_flush)
  );

  // Wrap-around instance
  logic        w_req, w_valid, w_stall, w_redirect, w_wr, w_flush;
  logic [31:0] w_addr, w_rdata, w_rpc, w_ins, w_pcnext;

  if_fetch_unit #(.INSWIDTH(32), .AWIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .imem_valid(w_valid),
    .stall(w_stall), .redirect(w_redirect), .redirect_pc(w_rpc),
    .insout(w_ins), .pcnextout(w_pcnext),
    .ifid_wr(w_wr), .ifid_flush(w_flush)
  );

  // ---------------- counters / scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];   // instructions expected to reach IF/ID, in order

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic        m_out, m_wrong, m_held;
  logic [31:0] m_hv;

  // memory model
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_data;
  int          lat_cfg;
  logic        lat_rand;
  logic        spur_en;
  logic [31:0] last_iss_addr;

  // observed outputs captured at the last compare point
  logic        obs_req, obs_wr, obs_flush;
  logic [31:0] obs_addr, obs_ins, obs_pcnext;
  logic        obs_wreq, obs_wwr;
  logic [31:0] obs_waddr, obs_wpcnext;

  // One clock: compare at negedge, advance model at posedge, new memory
  // response inputs #1 after the edge. Caller drives stall/redirect/rst_n.
  task automatic cycle();
    logic        e_req, e_wr, e_flush, issued;
    logic [31:0] e_ins, iss_addr;
    @(negedge clk);
    e_req   = rst_n && !m_out && !m_held;
    e_flush = rst_n && redirect;
    e_wr    = rst_n && !redirect && !stall &&
              ((m_out && !m_wrong && imem_valid) || m_held);
    e_ins   = m_held ? m_hv : imem_rdata;
    chk("imem_req",   {31'b0, imem_req},   {31'b0, e_req});
    chk("imem_addr",  imem_addr,           m_pc);
    chk("pcnextout",  pcnextout,           m_pc + 32'd4);
    chk("ifid_flush", {31'b0, ifid_flush}, {31'b0, e_flush});
    chk("ifid_wr",    {31'b0, ifid_wr},    {31'b0, e_wr});
    chk("insout",     insout,              e_ins);
    if (e_wr) begin
      if (exp_q.size() == 0) chk("scoreboard_empty", 32'd0, 32'd1);
      else chk("scoreboard_ins", insout, exp_q.pop_front());
    end
    obs_req = imem_req; obs_wr = ifid_wr; obs_flush = ifid_flush;
    obs_addr = imem_addr; obs_ins = insout; obs_pcnext = pcnextout;
    obs_wreq = w_req; obs_wwr = w_wr; obs_waddr = w_addr; obs_wpcnext = w_pcnext;

    @(posedge clk);
    issued   = e_req;
    iss_addr = m_pc;
    if (!rst_n) begin
      m_pc = RST_PC; m_out = 0; m_wrong = 0; m_held = 0; m_hv = 0;
      exp_q.delete();
    end else if (redirect) begin
      m_pc = redirect_pc & ~32'h3;
      if (m_held) m_held = 0;
      else if (!m_out) begin m_out = 1; m_wrong = 1; end
      else if (imem_valid) begin m_out = 0; m_wrong = 0; end
      else m_wrong = 1;
      exp_q.delete();
    end else begin
      if (m_held) begin
        if (!stall) begin m_held = 0; m_pc = m_pc + 32'd4; end
      end else if (!m_out) begin
        m_out = 1; m_wrong = 0;
      end else if (imem_valid) begin
        m_out = 0;
        if (m_wrong) m_wrong = 0;
        else if (stall) begin m_held = 1; m_hv = imem_rdata; end
        else m_pc = m_pc + 32'd4;
      end
    end
    // memory side
    if (!rst_n) begin
      mem_pend = 0; mem_cnt = 0;
    end else begin
      if (mem_pend) begin
        if (mem_cnt == 0) mem_pend = 0;
        else mem_cnt--;
      end
      if (issued) begin
        int lat;
        lat = lat_rand ? int'($urandom_range(1, 4)) : lat_cfg;
        mem_pend = 1; mem_cnt = lat - 1;
        mem_data = mem_word(iss_addr);
        last_iss_addr = iss_addr;
        exp_q.delete();
        exp_q.push_back(mem_data);
      end
    end
    #1;
    imem_valid = mem_pend && (mem_cnt == 0);
    imem_rdata = imem_valid ? mem_data : $urandom();
    // Unsolicited strobe while the unit is about to issue: must be ignored.
    if (spur_en && rst_n && !imem_valid && !mem_pend && !m_out && !m_held &&
        $urandom_range(0, 7) == 0)
      imem_valid = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && (m_out || m_held); i++) cycle();
    if (m_out || m_held) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40 && !imem_valid; i++) cycle();
    if (!imem_valid) chk("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] saved;
    int stall_run;
    rst_n = 0; stall = 0; redirect = 0; redirect_pc = 0;
    imem_valid = 0; imem_rdata = 0;
    w_valid = 0; w_rdata = 0; w_stall = 0; w_redirect = 0; w_rpc = 0;
    lat_cfg = 1; lat_rand = 0; spur_en = 0; last_iss_addr = 0;
    m_pc = RST_PC; m_out = 0; m_wrong = 0; m_held = 0; m_hv = 0;
    mem_pend = 0; mem_cnt = 0; mem_data = 0;

    // reset
    cycle(); cycle();
    chk("rst_req", {31'b0, obs_req}, 32'd0);
    chk("rst_wr",  {31'b0, obs_wr},  32'd0);
    rst_n = 1;

    // 1-cycle memory, first fetch; wrap instance alongside
    cycle();
    chk("t1_req",   {31'b0, obs_req}, 32'd1);
    chk("t1_addr",  obs_addr, 32'h0);
    chk("w_req",    {31'b0, obs_wreq}, 32'd1);
    chk("w_addr",   obs_waddr, 32'hFFFF_FFFC);
    w_valid = 1; w_rdata = 32'h1111_2222;
    cycle();
    chk("t1_wr",     {31'b0, obs_wr}, 32'd1);
    chk("t1_ins",    obs_ins, 32'h2008_0005);
    chk("t1_pcnext", obs_pcnext, 32'h4);
    chk("w_wr",      {31'b0, obs_wwr}, 32'd1);
    chk("w_pcnext",  obs_wpcnext, 32'h0);
    w_valid = 0;
    cycle();
    chk("t1_req2",  {31'b0, obs_req}, 32'd1);
    chk("t1_addr2", obs_addr, 32'h4);
    chk("w_req2",   {31'b0, obs_wreq}, 32'd1);
    chk("w_addr2",  obs_waddr, 32'h0);

    // latency 3, stall held 4 cycles from response
    wait_idle(); lat_cfg = 3;
    cycle();
    saved = mem_word(last_iss_addr);
    wait_valid();
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t2_wr_stalled",  {31'b0, obs_wr},  32'd0);
      chk("t2_req_stalled", {31'b0, obs_req}, 32'd0);
    end
    stall = 0;
    cycle();
    chk("t2_wr_release",  {31'b0, obs_wr}, 32'd1);
    chk("t2_ins_release", obs_ins, saved);

    // redirect in S_WAIT before the response
    wait_idle(); lat_cfg = 3;
    cycle();
    redirect = 1; redirect_pc = 32'h0000_0103;
    cycle();
    chk("t3_flush", {31'b0, obs_flush}, 32'd1);
    chk("t3_wr",    {31'b0, obs_wr},    32'd0);
    redirect = 0;
    wait_valid();
    cycle();
    chk("t3_stale_wr", {31'b0, obs_wr}, 32'd0);
    cycle();
    chk("t3_req",  {31'b0, obs_req}, 32'd1);
    chk("t3_addr", obs_addr, 32'h0000_0100);

    // redirect + valid + stall in the same cycle
    wait_idle(); lat_cfg = 2;
    cycle();
    wait_valid();
    redirect = 1; stall = 1; redirect_pc = 32'h0000_0200;
    cycle();
    chk("t4_flush", {31'b0, obs_flush}, 32'd1);
    chk("t4_wr",    {31'b0, obs_wr},    32'd0);
    redirect = 0; stall = 0;
    cycle();
    chk("t4_req",  {31'b0, obs_req}, 32'd1);
    chk("t4_addr", obs_addr, 32'h0000_0200);

    // redirect while holding under stall
    wait_idle(); lat_cfg = 1;
    cycle();
    wait_valid();
    stall = 1;
    cycle(); cycle();
    redirect = 1; redirect_pc = 32'h0000_0300;
    cycle();
    chk("t5_flush", {31'b0, obs_flush}, 32'd1);
    chk("t5_wr",    {31'b0, obs_wr},    32'd0);
    redirect = 0; stall = 0;
    cycle();
    chk("t5_req",  {31'b0, obs_req}, 32'd1);
    chk("t5_addr", obs_addr, 32'h0000_0300);

    // one-cycle reset while waiting
    wait_idle(); lat_cfg = 3;
    cycle();
    rst_n = 0; redirect = 1; redirect_pc = 32'h0000_0800;
    cycle();
    chk("t6_rst_req",   {31'b0, obs_req},   32'd0);
    chk("t6_rst_wr",    {31'b0, obs_wr},    32'd0);
    chk("t6_rst_flush", {31'b0, obs_flush}, 32'd0);
    rst_n = 1; redirect = 0;
    cycle();
    chk("t6_req",  {31'b0, obs_req}, 32'd1);
    chk("t6_addr", obs_addr, RST_PC);

    // randomized run
    lat_rand = 1; spur_en = 1; stall_run = 0;
    for (int i = 0; i < 4000; i++) begin
      if (stall_run > 0) begin
        stall = 1; stall_run--;
      end else begin
        stall = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 99) == 0) stall_run = int'($urandom_range(10, 30));
      end
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = $urandom();
      rst_n       = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
